// File: rtl/countermod6_pkg.sv
// rtl/countermod6_pkg.sv - shared timer digit types, limits and load saturation
//
// Purpose: common definitions for the microwave countdown timer digit
//          counters (countermod6 for tens of seconds, countermod10 for units).
// Contents:
//   DIGIT_W        width of one BCD digit
//   SEC_TENS_MAX   highest value of the tens-of-seconds digit
//   SEC_UNITS_MAX  highest value of the units-of-seconds digit
//   bcd_digit_t    BCD digit type shared by all digit counters
//   sat_digit()    clamps a loaded value to a digit's maximum

package countermod6_pkg;

   localparam int DIGIT_W       = 4;
   localparam int SEC_TENS_MAX  = 5;
   localparam int SEC_UNITS_MAX = 9;

   typedef logic [DIGIT_W-1:0] bcd_digit_t;

   // Keypad data can carry any nibble; clamp it so a counter never
   // starts from a digit outside its range.
   function automatic bcd_digit_t sat_digit(input bcd_digit_t d, input bcd_digit_t maxv);
      return (d > maxv) ? maxv : d;
   endfunction

endpackage

// File: rtl/countermod6.sv
// rtl/countermod6.sv - modulo-6 BCD down-counter for the tens-of-seconds digit
//
// Purpose: holds the tens-of-seconds digit (0..MAXVAL) of the countdown timer.
//          Parallel loadable, decrements when enabled, wraps 0 -> MAXVAL and
//          produces a borrow (tc) for the minutes digit.
// Ports:
//   clk    in   rising-edge clock
//   clrn   in   asynchronous clear, active-high (1 = clear)
//   data   in   parallel load value
//   loadn  in   synchronous load enable, active-low (wins over en)
//   en     in   count enable, one decrement per enabled edge
//   tens   out  current digit value
//   tc     out  borrow-out: en & (tens == 0), feeds en of the minutes digit
//   zero   out  tens == 0

module countermod6
   import countermod6_pkg::*;
#(
   parameter int WIDTH  = DIGIT_W,
   parameter int MAXVAL = SEC_TENS_MAX
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic [WIDTH-1:0] data,
   input  logic             loadn,
   input  logic             en,
   output logic [WIDTH-1:0] tens,
   output logic             tc,
   output logic             zero
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAXVAL);
   localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] load_val;

   assign load_val = WIDTH'(sat_digit(DIGIT_W'(data), DIGIT_W'(MAXVAL)));

   always_ff @(posedge clk or posedge clrn) begin
      if (clrn) begin
         count <= '0;
      end else if (!loadn) begin
         count <= load_val;
      end else if (en) begin
         // Out-of-range states are treated like 0 so the counter
         // recovers to a legal digit on the next enabled edge.
         if (count == '0 || count > MAXV) begin
            count <= MAXV;
         end else begin
            count <= count - ONE;
         end
      end
   end

   assign tens = count;
   assign zero = (count == '0);
   assign tc   = en & zero;

endmodule

// File: tb/tb_countermod6.sv
// tb/tb_countermod6.sv - directed self-checking bench for countermod6

module tb_countermod6;

   logic       clk;
   logic       clrn;
   logic [3:0] data;
   logic       loadn;
   logic       en;
   logic [3:0] tens;
   logic       tc;
   logic       zero;

   int vectors;
   int miscompares;

   countermod6 dut (
      .clk   (clk),
      .clrn  (clrn),
      .data  (data),
      .loadn (loadn),
      .en    (en),
      .tens  (tens),
      .tc    (tc),
      .zero  (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one rising edge, return 1 time unit after it
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clrn  = 1'b1;
      data  = 4'd7;
      loadn = 1'b0;
      en    = 1'b1;
      #2;
      vectors++;
      if (tens !== 4'd0) begin
         miscompares++;
         $display("FAIL reset_tens: got %0d expected 0", tens);
      end
      vectors++;
      if (zero !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_zero: got %b expected 1", zero);
      end
      vectors++;
      if (tc !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_tc_en1: got %b expected 1", tc);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         vectors++;
         if (tens !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_hold[%0d]: got %0d expected 0", i, tens);
         end
      end
      en = 1'b0;
      #1;
      vectors++;
      if (tc !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_tc_en0: got %b expected 0", tc);
      end
   endtask

   task automatic test_load();
      clrn  = 1'b0;
      data  = 4'd3;
      loadn = 1'b0;
      en    = 1'b0;
      tick();
      vectors++;
      if (tens !== 4'd3) begin
         miscompares++;
         $display("FAIL load3_tens: got %0d expected 3", tens);
      end
      vectors++;
      if (zero !== 1'b0) begin
         miscompares++;
         $display("FAIL load3_zero: got %b expected 0", zero);
      end
      loadn = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         vectors++;
         if (tens !== 4'd3) begin
            miscompares++;
            $display("FAIL hold3[%0d]: got %0d expected 3", i, tens);
         end
      end
   endtask

   task automatic test_saturate();
      logic [3:0] seq [7];
      seq = '{4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5, 4'd4};
      data  = 4'd15;
      loadn = 1'b0;
      en    = 1'b0;
      tick();
      vectors++;
      if (tens !== 4'd5) begin
         miscompares++;
         $display("FAIL sat_load15: got %0d expected 5", tens);
      end
      data = 4'd1;
      tick();
      data = 4'd6;
      tick();
      vectors++;
      if (tens !== 4'd5) begin
         miscompares++;
         $display("FAIL sat_load6: got %0d expected 5", tens);
      end
      loadn = 1'b1;
      en    = 1'b1;
      for (int i = 0; i < 7; i++) begin
         tick();
         vectors++;
         if (tens !== seq[i]) begin
            miscompares++;
            $display("FAIL count_seq[%0d]: got %0d expected %0d", i, tens, seq[i]);
         end
      end
   endtask

   task automatic test_borrow();
      data  = 4'd0;
      loadn = 1'b0;
      en    = 1'b0;
      tick();
      loadn = 1'b1;
      #1;
      vectors++;
      if (tc !== 1'b0 || zero !== 1'b1) begin
         miscompares++;
         $display("FAIL borrow_en0: got tc=%b zero=%b expected tc=0 zero=1", tc, zero);
      end
      en = 1'b1;
      #1;
      vectors++;
      if (tc !== 1'b1 || zero !== 1'b1) begin
         miscompares++;
         $display("FAIL borrow_en1: got tc=%b zero=%b expected tc=1 zero=1", tc, zero);
      end
      tick();
      vectors++;
      if (tens !== 4'd5 || tc !== 1'b0 || zero !== 1'b0) begin
         miscompares++;
         $display("FAIL borrow_wrap: got tens=%0d tc=%b zero=%b expected tens=5 tc=0 zero=0",
                  tens, tc, zero);
      end
   endtask

   task automatic test_priority();
      data  = 4'd2;
      loadn = 1'b0;
      en    = 1'b0;
      tick();
      vectors++;
      if (tens !== 4'd2) begin
         miscompares++;
         $display("FAIL prio_load2: got %0d expected 2", tens);
      end
      data = 4'd4;
      en   = 1'b1;
      tick();
      vectors++;
      if (tens !== 4'd4) begin
         miscompares++;
         $display("FAIL prio_load_over_en: got %0d expected 4", tens);
      end
      loadn = 1'b1;
      tick();
      vectors++;
      if (tens !== 4'd3) begin
         miscompares++;
         $display("FAIL prio_then_count: got %0d expected 3", tens);
      end
   endtask

   task automatic test_async_clear();
      en = 1'b0;
      tick();
      vectors++;
      if (tens !== 4'd3) begin
         miscompares++;
         $display("FAIL aclr_pre: got %0d expected 3", tens);
      end
      #2;
      clrn = 1'b1;
      #1;
      vectors++;
      if (tens !== 4'd0 || zero !== 1'b1) begin
         miscompares++;
         $display("FAIL aclr_mid_cycle: got tens=%0d zero=%b expected tens=0 zero=1", tens, zero);
      end
      #1;
      clrn = 1'b0;
      en   = 1'b1;
      tick();
      vectors++;
      if (tens !== 4'd5) begin
         miscompares++;
         $display("FAIL aclr_release_wrap: got %0d expected 5", tens);
      end
      tick();
      vectors++;
      if (tens !== 4'd4) begin
         miscompares++;
         $display("FAIL aclr_then_count: got %0d expected 4", tens);
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      test_reset();
      test_load();
      test_saturate();
      test_borrow();
      test_priority();
      test_async_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
